// File: rtl/redma_pkg.sv
// Shared types and defaults for the DMA write-side data path.
// The W engine imports the state enum and the width defaults from here.
package redma_pkg;

    localparam int DATA_WIDTH_DEF = 512;
    localparam int LEN_WIDTH_DEF  = 8;
    localparam int STRB_WIDTH_DEF = DATA_WIDTH_DEF / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } w_state_e;

    typedef struct packed {
        logic [LEN_WIDTH_DEF-1:0]  len;
        logic [STRB_WIDTH_DEF-1:0] first_strb;
        logic [STRB_WIDTH_DEF-1:0] last_strb;
    } w_cmd_t;

endpackage

// File: rtl/w_out_slot.sv
// One-entry valid/ready output register holding {data, strb, last}.
// A load overwrites the entry; a handshake without a load empties it.
module w_out_slot #(
    parameter int DATA_WIDTH = 512,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [STRB_WIDTH-1:0] in_strb,
    input  logic                  in_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [STRB_WIDTH-1:0] out_strb,
    output logic                  out_last,
    output logic                  slot_free
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            strb_d  = in_strb;
            last_d  = in_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    assign slot_free = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_strb  = strb_q;
    assign out_last  = last_q;

endmodule

// File: rtl/w_engine.sv
// DMA write-side data stage: pops FIFO beats into a registered AXI4 W slot,
// generating per-beat WSTRB, WLAST and a completion pulse per burst.
module w_engine
    import redma_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [STRB_WIDTH-1:0] cmd_first_strb,
    input  logic [STRB_WIDTH-1:0] cmd_last_strb,
    input  logic                  data_fifo_empty,
    input  logic [DATA_WIDTH-1:0] data_fifo_dout,
    output logic                  data_fifo_read,
    output logic [DATA_WIDTH-1:0] w_wdata,
    output logic [STRB_WIDTH-1:0] w_wstrb,
    output logic                  w_wlast,
    output logic                  w_wvalid,
    input  logic                  w_wready,
    output logic                  transaction_complete
);

    w_state_e              state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [STRB_WIDTH-1:0] first_q, first_d;
    logic [STRB_WIDTH-1:0] last_strb_q, last_strb_d;

    logic                  pop;
    logic                  slot_free;
    logic                  is_last_beat;
    logic [STRB_WIDTH-1:0] beat_strb_w;

    function automatic logic [STRB_WIDTH-1:0] beat_strb(
        input logic [LEN_WIDTH-1:0]  len,
        input logic [LEN_WIDTH-1:0]  cnt,
        input logic [STRB_WIDTH-1:0] fs,
        input logic [STRB_WIDTH-1:0] ls
    );
        if (len == '0)
            return fs & ls;
        else if (cnt == '0)
            return fs;
        else if (cnt == len)
            return ls;
        else
            return '1;
    endfunction

    // Equality is tested before the increment so len = all-ones never wraps early.
    assign is_last_beat = (cnt_q == len_q);
    assign beat_strb_w  = beat_strb(len_q, cnt_q, first_q, last_strb_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        last_strb_d = last_strb_q;
        cmd_ready   = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    len_d       = cmd_len;
                    first_d     = cmd_first_strb;
                    last_strb_d = cmd_last_strb;
                    cnt_d       = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                pop = !data_fifo_empty && slot_free;
                if (pop) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (is_last_beat)
                        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            first_q     <= '0;
            last_strb_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            last_strb_q <= last_strb_d;
        end
    end

    assign data_fifo_read = pop;

    w_out_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .in_data   (data_fifo_dout),
        .in_strb   (beat_strb_w),
        .in_last   (is_last_beat),
        .out_ready (w_wready),
        .out_valid (w_wvalid),
        .out_data  (w_wdata),
        .out_strb  (w_wstrb),
        .out_last  (w_wlast),
        .slot_free (slot_free)
    );

    assign transaction_complete = w_wvalid && w_wready && w_wlast;

endmodule

// File: tb/tb_w_engine.sv
// Directed-plus-random bench for w_engine: a FIFO model and a beat-level
// scoreboard built from burst commands predict every W handshake.
module tb_w_engine;

    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int LW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    typedef struct {
        logic [LW-1:0] len;
        logic [SW-1:0] fs;
        logic [SW-1:0] ls;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [SW-1:0] cmd_first_strb = '0;
    logic [SW-1:0] cmd_last_strb = '0;
    logic          data_fifo_empty = 1'b1;
    logic [DW-1:0] data_fifo_dout = '0;
    logic          data_fifo_read;
    logic [DW-1:0] w_wdata;
    logic [SW-1:0] w_wstrb;
    logic          w_wlast;
    logic          w_wvalid;
    logic          w_wready = 1'b0;
    logic          transaction_complete;

    w_engine #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_len              (cmd_len),
        .cmd_first_strb       (cmd_first_strb),
        .cmd_last_strb        (cmd_last_strb),
        .data_fifo_empty      (data_fifo_empty),
        .data_fifo_dout       (data_fifo_dout),
        .data_fifo_read       (data_fifo_read),
        .w_wdata              (w_wdata),
        .w_wstrb              (w_wstrb),
        .w_wlast              (w_wlast),
        .w_wvalid             (w_wvalid),
        .w_wready             (w_wready),
        .transaction_complete (transaction_complete)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    beat_t         exp_q[$];
    cmd_t          pend_q[$];

    int  rdy_mode    = 0;   // 0: always ready, 1: toggling, 2: random
    int  force_empty = 0;
    int  cyc         = 0;
    int  hs_count    = 0;
    int  tc_count    = 0;
    int  first_hs    = -1;
    int  last_hs     = -1;

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_strb;
    logic          prev_last;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected beats come straight from the strobe rules of each command.
    task automatic add_cmd(input logic [LW-1:0] len, input logic [SW-1:0] fs, input logic [SW-1:0] ls);
        cmd_t c;
        c.len = len; c.fs = fs; c.ls = ls;
        pend_q.push_back(c);
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            b.data = {$urandom, $urandom};
            if (len == 0)             b.strb = fs & ls;
            else if (i == 0)          b.strb = fs;
            else if (i == int'(len))  b.strb = ls;
            else                      b.strb = '1;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            fifo_q.push_back(b.data);
        end
    endtask

    task automatic drive_inputs();
        case (rdy_mode)
            0:       w_wready = 1'b1;
            1:       w_wready = cyc[0];
            default: w_wready = 1'($urandom_range(0, 1));
        endcase
        data_fifo_empty = (fifo_q.size() == 0) || (force_empty > 0);
        data_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : {$urandom, $urandom};
        if (pend_q.size() != 0) begin
            cmd_valid      = 1'b1;
            cmd_len        = pend_q[0].len;
            cmd_first_strb = pend_q[0].fs;
            cmd_last_strb  = pend_q[0].ls;
        end else begin
            cmd_valid      = 1'b0;
            cmd_len        = LW'($urandom);
            cmd_first_strb = SW'($urandom);
            cmd_last_strb  = SW'($urandom);
        end
    endtask

    // One clock: drive at posedge+1, check at posedge+4, update models after the edge.
    task automatic cycle();
        bit rd, acc, hs, exp_tc;
        drive_inputs();
        #3;
        rd  = data_fifo_read;
        acc = cmd_valid && cmd_ready;
        hs  = w_wvalid && w_wready;
        exp_tc = 1'b0;
        if (rd && data_fifo_empty) chk("read_while_empty", 1, 0);
        if (prev_stall) begin
            chk("stall_valid", w_wvalid, 1'b1);
            chk("stall_data", w_wdata, prev_data);
            chk("stall_strb", w_wstrb, prev_strb);
            chk("stall_last", w_wlast, prev_last);
        end
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", w_wdata, e.data);
                chk("beat_strb", w_wstrb, e.strb);
                chk("beat_last", w_wlast, e.last);
                exp_tc = e.last;
            end
            hs_count++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
        end
        chk("complete_pulse", transaction_complete, exp_tc);
        if (transaction_complete) tc_count++;
        prev_stall = w_wvalid && !w_wready;
        prev_data  = w_wdata;
        prev_strb  = w_wstrb;
        prev_last  = w_wlast;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (acc) void'(pend_q.pop_front());
        if (force_empty > 0) force_empty--;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pend_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        assert (pend_q.size() == 0 && exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout observed=%0d_beats_left expected=0", tag, exp_q.size());
        end
        cycle();
        cycle();
    endtask

    task automatic new_test();
        hs_count = 0; tc_count = 0; first_hs = -1; last_hs = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wvalid"}, w_wvalid, 1'b0);
        chk({tag, "_wlast"}, w_wlast, 1'b0);
        chk({tag, "_wstrb"}, w_wstrb, '0);
        chk({tag, "_wdata"}, w_wdata, '0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        chk({tag, "_fifo_read"}, data_fifo_read, 1'b0);
        chk({tag, "_complete"}, transaction_complete, 1'b0);
    endtask

    initial begin
        // Reset with the FIFO showing data
        rst = 1'b1;
        data_fifo_empty = 1'b0;
        data_fifo_dout  = 64'hDEAD_BEEF_0123_4567;
        cmd_valid = 1'b1;
        w_wready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        cmd_valid = 1'b0;
        data_fifo_empty = 1'b1;
        #2;
        chk("reset_release_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single beat: strobe is the AND of first and last
        new_test();
        rdy_mode = 0;
        add_cmd(8'd0, 8'hF0, 8'h0F);
        exp_q[0].data = {8{8'hA5}};
        fifo_q[0]     = {8{8'hA5}};
        drain("single", 50);
        chk("single_hs", hs_count, 1);
        chk("single_tc", tc_count, 1);

        // 4-beat burst, FIFO pre-filled, always ready: back-to-back beats
        new_test();
        add_cmd(8'd3, 8'hFE, 8'h7F);
        drain("burst4", 50);
        chk("burst4_hs", hs_count, 4);
        chk("burst4_tc", tc_count, 1);
        chk("burst4_contiguous", last_hs - first_hs, 3);

        // 8-beat burst with toggling ready and a 3-cycle FIFO gap
        new_test();
        rdy_mode = 1;
        add_cmd(8'd7, 8'hC0, 8'h03);
        repeat (5) cycle();
        force_empty = 3;
        drain("backpressure", 200);
        chk("backpressure_hs", hs_count, 8);
        chk("backpressure_tc", tc_count, 1);

        // Back-to-back commands len=1 then len=2
        new_test();
        rdy_mode = 0;
        add_cmd(8'd1, 8'hAA, 8'h55);
        add_cmd(8'd2, 8'h0F, 8'hF0);
        drain("b2b", 50);
        chk("b2b_hs", hs_count, 5);
        chk("b2b_tc", tc_count, 2);
        checks++;
        assert (last_hs - first_hs <= 5) else begin
            errors++;
            $error("FAIL b2b_gap observed=%0d expected<=5", last_hs - first_hs);
        end

        // Maximum length burst with random ready
        new_test();
        rdy_mode = 2;
        add_cmd(8'd255, SW'($urandom), SW'($urandom));
        drain("maxlen", 3000);
        chk("maxlen_hs", hs_count, 256);
        chk("maxlen_tc", tc_count, 1);

        // Several random bursts with random ready and random FIFO gaps
        new_test();
        for (int k = 0; k < 6; k++)
            add_cmd(LW'($urandom_range(0, 12)), SW'($urandom), SW'($urandom));
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) force_empty = $urandom_range(1, 3);
            cycle();
        end
        drain("random", 1000);
        chk("random_tc", tc_count, 6);

        // Reset in the middle of an 8-beat burst
        new_test();
        rdy_mode = 0;
        add_cmd(8'd7, 8'hFF, 8'hFF);
        while (hs_count < 3 && cyc < 100000) cycle();
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        pend_q.delete();
        prev_stall = 1'b0;
        new_test();
        add_cmd(8'd1, 8'h3C, 8'hC3);
        drain("after_reset", 50);
        chk("after_reset_hs", hs_count, 2);
        chk("after_reset_tc", tc_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/w_engine.md
Name: w_engine

Overview:
- DMA write-side data stage: pops beats from the read-data FIFO and drives the AXI4 W channel.
- Each burst is described by one command from the AW engine: beat count plus first-beat and last-beat byte strobes.
- Generates WLAST and WSTRB, and pulses transaction_complete when the final beat of a burst is accepted.
- Holds one registered output beat so there is no combinational path from FIFO data to W.

Parameters:
DATA_WIDTH, 512, AXI data width in bits; must be a power of two and at least 8.
STRB_WIDTH, DATA_WIDTH/8, strobe width (derived, not overridden).
LEN_WIDTH, 8, burst length field width; AXI awlen encoding (beats = len+1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_len  in  LEN_WIDTH  beats-1
cmd_first_strb  in  STRB_WIDTH  strobe for beat 0
cmd_last_strb  in  STRB_WIDTH  strobe for final beat
data_fifo_empty  in  1  FWFT FIFO empty; data_fifo_dout valid when low
data_fifo_dout  in  DATA_WIDTH  head-of-FIFO data
data_fifo_read  out  1  pop head this cycle
w_wdata  out  DATA_WIDTH  AXI WDATA
w_wstrb  out  STRB_WIDTH  AXI WSTRB
w_wlast  out  1  AXI WLAST
w_wvalid  out  1  AXI WVALID
w_wready  in  1  AXI WREADY
transaction_complete  out  1  one-cycle pulse on final-beat handshake

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, output slot empty.
  - Reset values: w_wvalid=0, w_wlast=0, w_wstrb=0, w_wdata=0, cmd_ready=0 during reset, data_fifo_read=0, transaction_complete=0.
- FSM IDLE:
  - cmd_ready=1.
  - On accept: latch len/first_strb/last_strb, clear counter, go to BURST.
- FSM BURST:
  - cmd_ready=0.
  - slot_free = !w_wvalid || w_wready.
  - data_fifo_read = !data_fifo_empty && slot_free (combinational).
  - Each pop loads the output slot with data_fifo_dout next cycle, sets w_wvalid, and increments the counter.
  - The pop of beat counter==len sets w_wlast on that beat and returns to IDLE.
- Strobe per beat:
  - len==0: first_strb & last_strb.
  - Beat 0: first_strb.
  - Beat len: last_strb.
  - Otherwise: all ones.
- Output slot:
  - w_wdata/w_wstrb/w_wlast are stable while w_wvalid && !w_wready (AXI rule).
  - Cleared to invalid on handshake when no pop occurs in the same cycle.
- Throughput: one beat per cycle sustained when the FIFO is non-empty and w_wready=1.
  - Latency from first pop to w_wvalid is 1 cycle.
- Back-to-back bursts:
  - The FSM is in IDLE while the last beat may still sit in the slot.
  - A new command may be accepted that cycle.
  - The new burst's first pop happens no earlier than the next cycle; the slot hand-off rule guarantees ordering.
- transaction_complete = w_wvalid && w_wready && w_wlast.
- FIFO empty mid-burst: no pop, w_wvalid drops after the slot drains, counter holds. No bubble beats and no WLAST change.
- w_wready low: no pop while the slot is full. The FIFO back-pressures upstream (the R engine stalls via full).
- Counter width is LEN_WIDTH; len=2^LEN_WIDTH-1 (256 beats) must not overflow. Compare on equality before increment.
- cmd_* values are ignored outside the IDLE handshake.
- Reset mid-burst:
  - Burst is abandoned and the slot is discarded.
  - No transaction_complete is pulsed.
  - FIFO contents are not touched; upstream resets concurrently.

Decomposition:
- Shared package (redma_pkg): DATA_WIDTH/LEN_WIDTH defaults, a w_cmd_t struct {len, first_strb, last_strb}, and the FSM state enum.
- Single optional sub-module w_out_slot: the one-entry valid/ready register holding {data, strb, last}. Everything else lives in w_engine.
- Port groups map onto the existing AXI4_W.master and FIFO_READ.master interfaces when instantiated in the top.

Test Plan:
- Reset: assert rst with FIFO non-empty -> w_wvalid=0, data_fifo_read=0, cmd_ready=0; after release, cmd_ready=1.
- Single beat: cmd len=0, first_strb=0xFF00..., last_strb=0x00FF..., one FIFO word 0xA5.. -> one W beat with wstrb = AND of the two strobes, wlast=1, transaction_complete pulses once.
- 4-beat burst, wready=1, FIFO pre-filled with D0..D3 -> 4 consecutive beats D0..D3.
  - Strobes: first_strb, all-ones, all-ones, last_strb.
  - wlast only on D3; complete pulse in the same cycle as the D3 handshake.
- Back-pressure: 8-beat burst, wready toggling 1/0 and FIFO empty for 3 cycles mid-burst -> data held stable while stalled, no duplicate or dropped beats, exactly 8 handshakes.
- Back-to-back: two commands len=1 and len=2 issued immediately -> 5 beats in order with at most one idle cycle between bursts; wlast on beats 2 and 5; two complete pulses.
- Max length: len=255 with random wready -> 256 beats, wlast only on beat 256, counter does not wrap early.
- Reset mid-burst: assert rst after beat 3 of 8 -> outputs return to reset values asynchronously; a fresh 2-beat burst completes correctly.
